spi_transaction_engine: RTL

- Cycle-accurate SPI master engine that sits directly downstream of the AXI-side SPI command/read FIFOs.
- Accepts a latched transaction descriptor (R/W, 10-bit address, word count) and serialises an 11-bit header plus N 32-bit data words on a mode-0 SPI bus.
- Write data is popped from the command FIFO; read data is pushed into the read FIFO.
- Signals completion with a one-cycle done pulse.

---
 rtl/spi_transaction_engine.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_transaction_engine.sv
// Mode-0 SPI master: sends an 11-bit {WnR, address} header and then N data words.
// Write words are popped from the command FIFO, and read words are pushed to the read FIFO.
module spi_transaction_engine #(
  parameter int DATA_WIDTH  = 32,
  parameter int HALF_PERIOD = 4
) (
  input  logic                  axi_clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  WnR,
  input  logic [9:0]            spi_address,
  input  logic [7:0]            spi_data_len,
  output logic                  busy,
  output logic                  done,
  output logic                  spi_command_rd_en,
  input  logic                  spi_command_empty,
  input  logic [DATA_WIDTH-1:0] spi_command_dout,
  output logic                  spi_read_wr_en,
  input  logic                  spi_read_full,
  output logic [DATA_WIDTH-1:0] spi_read_din,
  output logic                  pico,
  output logic                  cs_b,
  output logic                  spi_clk,
  input  logic                  poci
);

  localparam int PW = $clog2(2 * HALF_PERIOD);
  localparam logic [PW-1:0] PH_PRE_RISE = PW'(HALF_PERIOD - 1);
  localparam logic [PW-1:0] PH_RISE     = PW'(HALF_PERIOD);
  localparam logic [PW-1:0] PH_LAST     = PW'(2 * HALF_PERIOD - 1);
  localparam logic [12:0]   HDR_LAST    = 13'd10;
  localparam logic [12:0]   WORD_LAST   = 13'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, ZERO, HEADER, FETCH, DATA, STORE, HOLD} state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic [12:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]            word_cnt_q, word_cnt_d;
  logic                  wnr_q, wnr_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] read_din_q, read_din_d;
  logic                  pico_q, pico_d;
  logic                  cs_b_q, cs_b_d;
  logic                  spi_clk_q, spi_clk_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cmd_rd_q, cmd_rd_d;
  logic                  read_wr_q, read_wr_d;
  logic                  seg_last;

  // Next-state and next-output logic for the whole transaction sequencer
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    wnr_d      = wnr_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    read_din_d = read_din_q;
    pico_d     = pico_q;
    cs_b_d     = cs_b_q;
    spi_clk_d  = spi_clk_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cmd_rd_d   = 1'b0;
    read_wr_d  = 1'b0;
    seg_last   = (state_q == HEADER) ? (bit_cnt_q == HDR_LAST) : (bit_cnt_q == WORD_LAST);

    case (state_q)
      IDLE: begin
        if (start) begin
          wnr_d      = WnR;
          word_cnt_d = spi_data_len;
          if (spi_data_len == 8'd0) begin
            state_d = ZERO;
            done_d  = 1'b1;
          end else begin
            state_d   = HEADER;
            busy_d    = 1'b1;
            cs_b_d    = 1'b0;
            spi_clk_d = 1'b0;
            phase_d   = '0;
            bit_cnt_d = '0;
            tx_d      = {WnR, spi_address, {(DATA_WIDTH - 11){1'b0}}};
            pico_d    = WnR;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ZERO: state_d = IDLE;
      HEADER, DATA: begin
        if (phase_q != PH_LAST) begin
          phase_d   = phase_q + 1'b1;
          spi_clk_d = (phase_q == PH_PRE_RISE) ? 1'b1 : spi_clk_q;
          if (state_q == DATA && !wnr_q && phase_q == PH_RISE) begin
            rx_d = {rx_q[DATA_WIDTH-2:0], poci};
          end else begin
            rx_d = rx_q;
          end
        end else begin
          phase_d   = '0;
          spi_clk_d = 1'b0;
          if (!seg_last) begin
            bit_cnt_d = bit_cnt_q + 13'd1;
            tx_d      = tx_q << 1;
            pico_d    = (state_q == DATA && !wnr_q) ? 1'b0 : tx_q[DATA_WIDTH-2];
          end else begin
            bit_cnt_d = '0;
            if (state_q == HEADER) begin
              if (wnr_q) begin
                state_d = FETCH;
              end else begin
                state_d = DATA;
                pico_d  = 1'b0;
              end
            end else begin
              word_cnt_d = word_cnt_q - 8'd1;
              if (!wnr_q) begin
                state_d = STORE;
              end else if (word_cnt_q == 8'd1) begin
                state_d = HOLD;
              end else begin
                state_d = FETCH;
              end
            end
          end
        end
      end
      FETCH: state_d = FETCH;
      STORE: begin
        if (!spi_read_full) begin
          read_wr_d  = 1'b1;
          read_din_d = rx_q;
          state_d    = (word_cnt_q == 8'd0) ? HOLD : DATA;
        end else begin
          state_d = STORE;
        end
      end
      HOLD: begin
        if (phase_q == PH_PRE_RISE) begin
          state_d = IDLE;
          cs_b_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A waiting word is taken in the same cycle, so FETCH only costs time on underflow
    if (state_d == FETCH && !spi_command_empty) begin
      state_d  = DATA;
      tx_d     = spi_command_dout;
      pico_d   = spi_command_dout[DATA_WIDTH-1];
      cmd_rd_d = 1'b1;
    end else begin
      cmd_rd_d = cmd_rd_d;
    end
  end

  // Sequencer state, counters and registered outputs
  always_ff @(posedge axi_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      wnr_q      <= 1'b0;
      tx_q       <= '0;
      rx_q       <= '0;
      read_din_q <= '0;
      pico_q     <= 1'b0;
      cs_b_q     <= 1'b1;
      spi_clk_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cmd_rd_q   <= 1'b0;
      read_wr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      wnr_q      <= wnr_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      read_din_q <= read_din_d;
      pico_q     <= pico_d;
      cs_b_q     <= cs_b_d;
      spi_clk_q  <= spi_clk_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cmd_rd_q   <= cmd_rd_d;
      read_wr_q  <= read_wr_d;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign spi_command_rd_en = cmd_rd_q;
  assign spi_read_wr_en    = read_wr_q;
  assign spi_read_din      = read_din_q;
  assign pico              = pico_q;
  assign cs_b              = cs_b_q;
  assign spi_clk           = spi_clk_q;

endmodule
